pattern_detector_n: RTL and testbench

Parametrised serial bit-pattern detector, successor to the fixed 5-bit sequence FSMs. It detects a run-time programmable LEN-bit pattern with a per-bit don't-care mask, selectable overlapping or non-overlapping detection, input qualification via a valid strobe, and a saturating match counter. It sits on the serial data path and drives one-cycle match pulses to downstream control logic.

---
 rtl/pattern_detector_n.sv | 103 ++++++++++
 tb/tb_pattern_detector_n.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_n.sv
// Serial detector for a programmable LEN-bit pattern with per-bit don't-care mask,
// overlap/non-overlap detection, valid qualification and a saturating match counter.
module pattern_detector_n #(
  parameter int             LEN             = 5,
  parameter logic [LEN-1:0] DEFAULT_PATTERN = 5'b11011,
  parameter logic           DEFAULT_OVERLAP = 1'b1,
  parameter int             CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             data_in,
  input  logic             cfg_we,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic [LEN-1:0]   cfg_care,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             match_out,
  output logic [CNT_W-1:0] match_count,
  output logic             primed
);

  localparam int             FW   = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(LEN);

  logic [LEN-1:0]   hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [LEN-1:0]   pattern_q, pattern_d;
  logic [LEN-1:0]   care_q, care_d;
  logic             overlap_q, overlap_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             primed_q, primed_d;

  logic             accept;
  logic [LEN-1:0]   next_hist;
  logic [FW-1:0]    next_fill;
  logic             hit;

  // A configuration write wins over a same-cycle data bit, which is dropped.
  assign accept    = in_valid && !cfg_we;
  assign next_hist = {hist_q[LEN-2:0], data_in};
  assign next_fill = (fill_q == FULL) ? FULL : fill_q + FW'(1);
  assign hit       = accept && (next_fill == FULL) &&
                     (((next_hist ^ pattern_q) & care_q) == '0);

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    care_d    = care_q;
    overlap_d = overlap_q;
    match_d   = hit;
    count_d   = count_q;

    if (cfg_we) begin
      pattern_d = cfg_pattern;
      care_d    = cfg_care;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d = next_hist;
      // Non-overlap mode restarts the fill so the next match needs LEN fresh bits.
      fill_d = (hit && !overlap_q) ? '0 : next_fill;
    end

    if (clr_count) begin
      count_d = '0;
    end else if (hit && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end

    primed_d = (fill_d == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEFAULT_PATTERN;
      care_q    <= '1;
      overlap_q <= DEFAULT_OVERLAP;
      match_q   <= 1'b0;
      count_q   <= '0;
      primed_q  <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      care_q    <= care_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
      count_q   <= count_d;
      primed_q  <= primed_d;
    end
  end

  assign match_out   = match_q;
  assign match_count = count_q;
  assign primed      = primed_q;

endmodule

// File: tb/tb_pattern_detector_n.sv
// Scoreboard bench for pattern_detector_n: the driver queues the expected outputs of
// every cycle it issues, and a monitor checks them one step after each rising edge.
module tb_pattern_detector_n;

  localparam int LEN   = 5;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             data_in = 1'b0;
  logic             cfg_we = 1'b0;
  logic [LEN-1:0]   cfg_pattern = '0;
  logic [LEN-1:0]   cfg_care = '0;
  logic             cfg_overlap = 1'b0;
  logic             clr_count = 1'b0;
  logic             match_out;
  logic [CNT_W-1:0] match_count;
  logic             primed;

  always #5 clk = ~clk;

  pattern_detector_n #(
    .LEN(LEN), .DEFAULT_PATTERN(5'b11011), .DEFAULT_OVERLAP(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_care(cfg_care),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .match_out(match_out), .match_count(match_count), .primed(primed)
  );

  typedef struct packed {
    logic             m;
    logic [CNT_W-1:0] c;
    logic             p;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  string tag = "init";
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk({tag, " match_out"},   32'(match_out),   32'(mon_e.m));
      chk({tag, " match_count"}, 32'(match_count), 32'(mon_e.c));
      chk({tag, " primed"},      32'(primed),      32'(mon_e.p));
    end
  end

  task automatic cyc(input logic r, input logic v, input logic d, input logic we,
                     input logic clr, input logic em, input int ec, input logic ep);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; data_in = d; cfg_we = we; clr_count = clr;
    e.m = em; e.c = ec[CNT_W-1:0]; e.p = ep;
    sb_q.push_back(e);
  endtask

  task automatic bit_in(input logic d, input logic em, input int ec, input logic ep);
    cyc(1'b1, 1'b1, d, 1'b0, 1'b0, em, ec, ep);
  endtask

  task automatic idle(input logic d, input int ec, input logic ep);
    cyc(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, ec, ep);
  endtask

  task automatic cfg(input logic [LEN-1:0] pat, input logic [LEN-1:0] care,
                     input logic ov, input int ec);
    cfg_pattern = pat; cfg_care = care; cfg_overlap = ov;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ec, 1'b0);
  endtask

  task automatic clr(input logic ep);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, ep);
  endtask

  // Stream 1,1,0,1,1,0,1,1 against 11011 in overlap mode.
  logic [7:0] stream = 8'b11011011;
  int ov_m[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
  int ov_c[8] = '{0, 0, 0, 0, 1, 1, 1, 2};
  int sat_c[10] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3};

  initial begin
    tag = "reset";
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    tag = "overlap";
    for (int i = 0; i < 8; i++) bit_in(stream[7-i], ov_m[i][0], ov_c[i], i >= 4);
    clr(1'b1);

    tag = "nonoverlap";
    cfg(5'b11011, 5'b11111, 1'b0, 0);
    for (int i = 0; i < 8; i++)
      bit_in(stream[7-i], i == 4, (i >= 4) ? 1 : 0, 1'b0);
    clr(1'b0);

    tag = "gaps";
    cfg(5'b11011, 5'b11111, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      bit_in(stream[7-i], ov_m[i][0], ov_c[i], i >= 4);
      for (int g = 0; g <= (i % 3); g++) idle(g[0] ^ stream[7-i], ov_c[i], i >= 4);
    end
    clr(1'b1);

    tag = "dontcare";
    cfg(5'b11011, 5'b11011, 1'b1, 0);
    for (int i = 0; i < 5; i++) bit_in(1'b1, i == 4, (i == 4) ? 1 : 0, i == 4);
    tag = "care_all";
    cfg(5'b11011, 5'b11111, 1'b1, 1);
    for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b0, 1, i == 4);
    clr(1'b1);

    tag = "rst_mid";
    cfg(5'b00000, 5'b11111, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    tag = "post_rst_defaults";
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b1);
    clr(1'b1);

    tag = "cfg_mid";
    cfg(5'b11011, 5'b11111, 1'b1, 0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);

    tag = "saturate";
    cfg(5'b11111, 5'b11111, 1'b1, 0);
    for (int i = 0; i < 10; i++) bit_in(1'b1, i >= 4, sat_c[i], i >= 4);
    tag = "clr_on_hit";
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    bit_in(1'b1, 1'b1, 1, 1'b1);
    idle(1'b1, 1, 1'b1);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
